// File: rtl/hdlc_mon_pkg.sv
// Shared constants, check identifiers and saturating-add helper for the HDLC Rx monitor.
package hdlc_mon_pkg;

    localparam logic [7:0] FLAG_PAT  = 8'b0111_1110;
    localparam logic [7:0] ABORT_PAT = 8'b0111_1111;
    localparam logic [7:0] IDLE_PAT  = 8'hFF;

    typedef enum logic [1:0] {
        CHK_FLAG,
        CHK_ABORT,
        CHK_EOF,
        CHK_SPUR
    } chk_id_e;

    // Adds inc to val and clamps the result at max; the sum is widened so it cannot wrap.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] inc,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, val} + {1'b0, inc};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

endpackage

// File: rtl/hdlc_mon_expect.sv
// Latency expectation pipe: a trigger seen now must be answered by target exactly DEPTH
// cycles later. Each trigger travels independently, so overlapping triggers are fine.
module hdlc_mon_expect #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic trig_i,
    input  logic target_i,
    output logic err_o,
    output logic tap_o
);

    logic [DEPTH-1:0] pipe_q, pipe_d;

    // Shift the trigger history one stage per cycle.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = trig_i;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Expectation register; reset drops every pending expectation silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tap_o = pipe_q[DEPTH-1];
    assign err_o = tap_o && !target_i;

endmodule

// File: rtl/hdlc_rx_monitor.sv
// Runtime checker for the HDLC Rx path: flag/abort/EoF latency checks, optional spurious
// flag check, saturating error counters and first-error capture.
// Optional: define HDLC_MON_TIMESTAMP_EN to build the cycle counter behind FirstErrTime.
module hdlc_rx_monitor
    import hdlc_mon_pkg::*;
#(
    parameter int unsigned FLAG_LAT  = 2,
    parameter int unsigned ABORT_LAT = 1,
    parameter int unsigned EOF_LAT   = 1,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned STRICT    = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Clr,
    input  logic                 Rx,
    input  logic                 Rx_FlagDetect,
    input  logic                 Rx_ValidFrame,
    input  logic                 Rx_AbortDetect,
    input  logic                 Rx_AbortSignal,
    input  logic                 Rx_EoF,
    output logic [3:0]           ErrPulse,
    output logic [4*CNT_W-1:0]   ErrCnt,
    output logic [CNT_W+1:0]     ErrTotal,
    output logic [CNT_W-1:0]     FlagCnt,
    output logic                 FirstErrValid,
    output logic [1:0]           FirstErrId,
    output logic [31:0]          FirstErrTime
);

    localparam logic [31:0] CntMax = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0] TotMax = 32'((64'd1 << (CNT_W + 2)) - 64'd1);

    // Only the previous seven bits are needed: the window is completed by the live Rx bit.
    logic [6:0] sr_q;
    logic [3:0] fill_q, fill_d;
    logic       vf_q;
    logic [7:0] window;
    logic       flag_m;

    assign window = {sr_q, Rx};
    assign fill_d = (fill_q == 4'd8) ? fill_q : fill_q + 4'd1;
    // Abort and idle windows deliberately drive nothing; aborts are checked via Rx_AbortDetect.
    assign flag_m = (fill_q >= 4'd7) && (window == FLAG_PAT);

    // History, fill level and frame-valid edge tracking.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sr_q   <= 7'h7F;
            fill_q <= '0;
            vf_q   <= 1'b0;
        end else begin
            sr_q   <= window[6:0];
            fill_q <= fill_d;
            vf_q   <= Rx_ValidFrame;
        end
    end

    logic flag_err, abort_err, eof_err, spur_err, flag_tap;

    hdlc_mon_expect #(.DEPTH(FLAG_LAT)) u_exp_flag (
        .clk_i    (Clk),
        .rst_i    (Rst),
        .trig_i   (flag_m),
        .target_i (Rx_FlagDetect),
        .err_o    (flag_err),
        .tap_o    (flag_tap)
    );

    hdlc_mon_expect #(.DEPTH(ABORT_LAT)) u_exp_abort (
        .clk_i    (Clk),
        .rst_i    (Rst),
        .trig_i   (Rx_AbortDetect && Rx_ValidFrame),
        .target_i (Rx_AbortSignal),
        .err_o    (abort_err),
        .tap_o    ()
    );

    hdlc_mon_expect #(.DEPTH(EOF_LAT)) u_exp_eof (
        .clk_i    (Clk),
        .rst_i    (Rst),
        .trig_i   (vf_q && !Rx_ValidFrame),
        .target_i (Rx_EoF),
        .err_o    (eof_err),
        .tap_o    ()
    );

    assign spur_err = (STRICT != 0) && Rx_FlagDetect && !flag_tap;

    logic [31:0] stamp;
`ifdef HDLC_MON_TIMESTAMP_EN
    logic [31:0] ts_q;

    // Free-running cycle stamp, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end
    assign stamp = ts_q;
`else
    assign stamp = '0;
`endif

    logic [3:0]       err_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [CNT_W+1:0] total_q, total_d;
    logic [CNT_W-1:0] flagcnt_q, flagcnt_d;
    logic             fvalid_q, fvalid_d;
    chk_id_e          fid_q, fid_d;
    logic [31:0]      ftime_q, ftime_d;

    // Counter and capture update; Clr wins over an error pulse in the same cycle.
    always_comb begin
        cnt_d     = cnt_q;
        total_d   = total_q;
        flagcnt_d = flagcnt_q;
        fvalid_d  = fvalid_q;
        fid_d     = fid_q;
        ftime_d   = ftime_q;
        if (Clr) begin
            cnt_d     = '{default: '0};
            total_d   = '0;
            flagcnt_d = '0;
            fvalid_d  = 1'b0;
            fid_d     = CHK_FLAG;
            ftime_d   = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (err_q[i]) begin
                    cnt_d[i] = CNT_W'(sat_inc(32'(cnt_q[i]), 32'd1, CntMax));
                end
            end
            total_d = (CNT_W + 2)'(sat_inc(32'(total_q), 32'($countones(err_q)), TotMax));
            if (flag_m) begin
                flagcnt_d = CNT_W'(sat_inc(32'(flagcnt_q), 32'd1, CntMax));
            end
            if (!fvalid_q && (err_q != '0)) begin
                fvalid_d = 1'b1;
                ftime_d  = stamp;
                if (err_q[0]) begin
                    fid_d = CHK_FLAG;
                end else if (err_q[1]) begin
                    fid_d = CHK_ABORT;
                end else if (err_q[2]) begin
                    fid_d = CHK_EOF;
                end else begin
                    fid_d = CHK_SPUR;
                end
            end
        end
    end

    // Registered error strobes and statistics state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            err_q     <= '0;
            cnt_q     <= '{default: '0};
            total_q   <= '0;
            flagcnt_q <= '0;
            fvalid_q  <= 1'b0;
            fid_q     <= CHK_FLAG;
            ftime_q   <= '0;
        end else begin
            err_q     <= {spur_err, eof_err, abort_err, flag_err};
            cnt_q     <= cnt_d;
            total_q   <= total_d;
            flagcnt_q <= flagcnt_d;
            fvalid_q  <= fvalid_d;
            fid_q     <= fid_d;
            ftime_q   <= ftime_d;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign ErrCnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign ErrPulse      = err_q;
    assign ErrTotal      = total_q;
    assign FlagCnt       = flagcnt_q;
    assign FirstErrValid = fvalid_q;
    assign FirstErrId    = fid_q;
    assign FirstErrTime  = ftime_q;

endmodule

// File: tb/tb_hdlc_rx_monitor.sv
// Self-checking bench for hdlc_rx_monitor: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the check rules. A second instance
// with STRICT=1 shares the stimulus to cover the spurious-flag check.
module tb_hdlc_rx_monitor;

    localparam int unsigned FLAG_LAT  = 2;
    localparam int unsigned ABORT_LAT = 1;
    localparam int unsigned EOF_LAT   = 1;
    localparam int unsigned CNT_W     = 8;
    localparam int CMAX = (1 << CNT_W) - 1;
    localparam int TMAX = (1 << (CNT_W + 2)) - 1;

    logic Clk = 1'b0;
    logic Rst, Clr, Rx, fd, vf, ad, ab_sig, eof;

    logic [3:0]         ErrPulse, s_pulse;
    logic [4*CNT_W-1:0] ErrCnt, s_cnt;
    logic [CNT_W+1:0]   ErrTotal, s_total;
    logic [CNT_W-1:0]   FlagCnt, s_flagcnt;
    logic               FirstErrValid, s_fvalid;
    logic [1:0]         FirstErrId, s_fid;
    logic [31:0]        FirstErrTime, s_ftime;

    hdlc_rx_monitor #(
        .FLAG_LAT(FLAG_LAT), .ABORT_LAT(ABORT_LAT), .EOF_LAT(EOF_LAT), .CNT_W(CNT_W), .STRICT(0)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Clr(Clr), .Rx(Rx),
        .Rx_FlagDetect(fd), .Rx_ValidFrame(vf), .Rx_AbortDetect(ad),
        .Rx_AbortSignal(ab_sig), .Rx_EoF(eof),
        .ErrPulse(ErrPulse), .ErrCnt(ErrCnt), .ErrTotal(ErrTotal), .FlagCnt(FlagCnt),
        .FirstErrValid(FirstErrValid), .FirstErrId(FirstErrId), .FirstErrTime(FirstErrTime)
    );

    hdlc_rx_monitor #(
        .FLAG_LAT(FLAG_LAT), .ABORT_LAT(ABORT_LAT), .EOF_LAT(EOF_LAT), .CNT_W(CNT_W), .STRICT(1)
    ) dut_s (
        .Clk(Clk), .Rst(Rst), .Clr(Clr), .Rx(Rx),
        .Rx_FlagDetect(fd), .Rx_ValidFrame(vf), .Rx_AbortDetect(ad),
        .Rx_AbortSignal(ab_sig), .Rx_EoF(eof),
        .ErrPulse(s_pulse), .ErrCnt(s_cnt), .ErrTotal(s_total), .FlagCnt(s_flagcnt),
        .FirstErrValid(s_fvalid), .FirstErrId(s_fid), .FirstErrTime(s_ftime)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: bit history, due-cycle queues of pending expectations, stats.
    longint      cyc = 0;
    bit   [6:0]  hist;
    int          nbits;
    bit          vf_prev;
    longint      fq[$], aq[$], eq[$];
    bit   [3:0]  mp, sp;
    int          cnt[4];
    int          total, flagcnt, scnt3;
    bit          fvalid;
    int          fid;
    logic [31:0] ftime, ts;
    bit          trk_fd, trk_as, trk_eof;
    bit          txq[$];

    function automatic int sat(input int v, input int inc, input int mx);
        return (v + inc > mx) ? mx : v + inc;
    endfunction

    function automatic bit tap_now(input int which);
        case (which)
            0:       return (fq.size() != 0) && (fq[0] == cyc);
            1:       return (aq.size() != 0) && (aq[0] == cyc);
            default: return (eq.size() != 0) && (eq[0] == cyc);
        endcase
    endfunction

    task automatic model_reset();
        hist = 7'h7F; nbits = 0; vf_prev = 0;
        fq.delete(); aq.delete(); eq.delete();
        mp = '0; sp = '0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        total = 0; flagcnt = 0; scnt3 = 0; fvalid = 0; fid = 0; ftime = '0; ts = '0;
    endtask

    // Advances the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        bit [7:0] w;
        bit       fm, tf, ta, te, spur;
        bit [2:0] e;
        if (Rst) begin
            model_reset();
            cyc++;
            return;
        end
        w  = {hist, Rx};
        fm = (nbits >= 7) && (w == 8'b0111_1110);
        tf = tap_now(0); if (tf) void'(fq.pop_front());
        ta = tap_now(1); if (ta) void'(aq.pop_front());
        te = tap_now(2); if (te) void'(eq.pop_front());
        e    = {te && !eof, ta && !ab_sig, tf && !fd};
        spur = fd && !tf;
        if (fm) fq.push_back(cyc + FLAG_LAT);
        if (ad && vf) aq.push_back(cyc + ABORT_LAT);
        if (vf_prev && !vf) eq.push_back(cyc + EOF_LAT);
        if (Clr) begin
            for (int i = 0; i < 4; i++) cnt[i] = 0;
            total = 0; flagcnt = 0; scnt3 = 0; fvalid = 0; fid = 0; ftime = '0;
        end else begin
            for (int i = 0; i < 4; i++) if (mp[i]) cnt[i] = sat(cnt[i], 1, CMAX);
            total = sat(total, $countones(mp), TMAX);
            if (fm) flagcnt = sat(flagcnt, 1, CMAX);
            if (sp[3]) scnt3 = sat(scnt3, 1, CMAX);
            if (!fvalid && mp != 0) begin
                fvalid = 1;
                ftime  = ts;
                fid    = mp[0] ? 0 : (mp[1] ? 1 : (mp[2] ? 2 : 3));
            end
        end
        hist    = w[6:0];
        nbits   = (nbits < 8) ? nbits + 1 : 8;
        vf_prev = vf;
        ts      = ts + 32'd1;
        cyc++;
        mp = {1'b0, e};
        sp = {spur, e};
    endtask

    task automatic compare_all();
        logic [31:0] exp_cnt;
        exp_cnt = {8'(cnt[3]), 8'(cnt[2]), 8'(cnt[1]), 8'(cnt[0])};
        check_eq("err_pulse", ErrPulse, mp);
        check_eq("err_pulse_strict", s_pulse, sp);
        check_eq("err_cnt", ErrCnt, exp_cnt);
        check_eq("err_total", ErrTotal, total);
        check_eq("flag_cnt", FlagCnt, flagcnt);
        check_eq("first_valid", FirstErrValid, fvalid);
        check_eq("first_id", FirstErrId, fid);
`ifdef HDLC_MON_TIMESTAMP_EN
        check_eq("first_time", FirstErrTime, ftime);
`else
        check_eq("first_time", FirstErrTime, 0);
`endif
        check_eq("spur_cnt_strict", s_cnt[31:24], scnt3);
    endtask

    task automatic tick();
        if (trk_fd)  fd     = tap_now(0);
        if (trk_as)  ab_sig = tap_now(1);
        if (trk_eof) eof    = tap_now(2);
        model_step();
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    task automatic send_byte(input bit [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            Rx = b[i];
            tick();
        end
    endtask

    task automatic idle(input int n);
        Rx = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        bit hit;
        Rst = 1; Clr = 0; Rx = 1; fd = 0; vf = 0; ad = 0; ab_sig = 0; eof = 0;
        trk_fd = 0; trk_as = 0; trk_eof = 0;
        model_reset();
        #2;
        tick(); tick();
        check_eq("rst_pulse", ErrPulse, 0);
        check_eq("rst_cnt", ErrCnt, 0);
        check_eq("rst_valid", FirstErrValid, 0);
        Rst = 0;

        // Correctly answered flag.
        trk_fd = 1;
        send_byte(8'hFF); send_byte(8'h7E); idle(4);
        check_eq("flag_ok_cnt", FlagCnt, 1);
        check_eq("flag_ok_nerr", ErrCnt, 0);

        // Missing FlagDetect: pulse lands one cycle after the expected slot.
        trk_fd = 0; fd = 0;
        send_byte(8'h7E);
        idle(1);
        check_eq("flag_err_early", ErrPulse, 0);
        idle(1);
        check_eq("flag_err_slot", ErrPulse, 4'b0001);
        idle(3);
        check_eq("flag_err_cnt", ErrCnt[7:0], 1);
        check_eq("flag_err_valid", FirstErrValid, 1);
        check_eq("flag_err_id", FirstErrId, 0);

        // Abort without AbortSignal, then a correctly answered EoF.
        vf = 1; idle(2);
        ad = 1; ab_sig = 0; tick();
        ad = 0; idle(3);
        check_eq("abort_err_cnt", ErrCnt[15:8], 1);
        trk_eof = 1; vf = 0; idle(4);
        check_eq("eof_ok_cnt", ErrCnt[23:16], 0);
        trk_eof = 0; eof = 0;

        // Saturation: 1100 back-to-back flags sharing their end zero, all unanswered.
        Clr = 1; tick(); Clr = 0;
        for (int k = 0; k < 1100; k++) begin
            Rx = 0; tick();
            repeat (6) begin Rx = 1; tick(); end
        end
        Rx = 0; tick();
        idle(4);
        check_eq("sat_flag_cnt", ErrCnt[7:0], CMAX);
        check_eq("sat_total", ErrTotal, TMAX);
        check_eq("sat_flagcnt", FlagCnt, CMAX);

        // Clr coinciding with an error pulse wins.
        send_byte(8'h7E);
        hit = 0;
        for (int k = 0; k < 6 && !hit; k++) begin
            if (mp != 0) begin
                Clr = 1; tick(); Clr = 0; hit = 1;
            end else begin
                tick();
            end
        end
        idle(3);
        check_eq("clr_cnt", ErrCnt, 0);
        check_eq("clr_total", ErrTotal, 0);
        check_eq("clr_valid", FirstErrValid, 0);

        // Reset drops a pending flag check, and a flag cut by reset never matches.
        send_byte(8'hFF); send_byte(8'h7E);
        Rst = 1; Rx = 1; tick(); Rst = 0;
        send_byte(8'hFF);
        Rx = 0; tick(); Rx = 1; tick(); tick();
        Rst = 1; tick(); Rst = 0;
        repeat (4) begin Rx = 1; tick(); end
        Rx = 0; tick();
        idle(4);
        check_eq("rstmid_cnt", ErrCnt, 0);
        check_eq("rstmid_flagcnt", FlagCnt, 0);
        check_eq("rstmid_valid", FirstErrValid, 0);

        // First error stamped at cycle 1000 after reset.
        Rst = 1; tick(); Rst = 0;
        idle(990);
        send_byte(8'h7E);
        idle(4);
        check_eq("ts_valid", FirstErrValid, 1);
        check_eq("ts_id", FirstErrId, 0);
`ifdef HDLC_MON_TIMESTAMP_EN
        check_eq("ts_time", FirstErrTime, 1000);
`else
        check_eq("ts_time", FirstErrTime, 0);
`endif

        // Randomized traffic with mostly-correct responses.
        Clr = 1; tick(); Clr = 0;
        for (int c = 0; c < 3000; c++) begin
            if (txq.size() == 0) begin
                bit [7:0] b;
                case ($urandom_range(3))
                    0:       b = 8'h7E;
                    1:       b = 8'h7F;
                    default: b = 8'($urandom);
                endcase
                for (int i = 7; i >= 0; i--) txq.push_back(b[i]);
            end
            Rx     = txq.pop_front();
            if ($urandom_range(15) == 0) vf = ~vf;
            ad     = ($urandom_range(7) == 0);
            fd     = tap_now(0) ^ ($urandom_range(19) == 0);
            ab_sig = tap_now(1) ^ ($urandom_range(9) == 0);
            eof    = tap_now(2) ^ ($urandom_range(9) == 0);
            Clr    = ($urandom_range(199) == 0);
            Rst    = ($urandom_range(499) == 0);
            tick();
        end
        Rst = 0; Clr = 0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
